serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Processes WIDTH-bit operands LSB-first, one bit per clock, through a single 1-bit full-adder cell.
- Successor to the combinational 1-bit full adder: generalised width, add/subtract mode, borrow/carry-in, signed overflow, and a start/busy/done handshake.
- Sits in the datapath wherever area matters more than latency, e.g. accumulators and low-rate arithmetic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- clear  in  1  synchronous abort to IDLE; overrides start.
- sub  in  1  0 = a+b+cin, 1 = a-b-cin (cin acts as borrow-in); latched on accepted start.
- cin  in  1  carry/borrow-in; latched on accepted start.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result, cout and ovf are valid.
- result  out  WIDTH  sum/difference; holds its value until the next op completes.
- cout  out  1  carry-out; for subtract this is NOT borrow-out.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, all internal registers 0. Reset takes effect immediately, including mid-RUN; the partial operation is discarded.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE -> RUN on start=1 and clear=0.
  - RUN -> DONE after WIDTH bit-steps.
  - DONE -> RUN on start=1 and clear=0; otherwise DONE -> IDLE.
  - clear=1 in any state -> IDLE next edge; done=0; result, cout and ovf keep their last completed values.
- Accept action on edge k:
  - opA <= a.
  - opB <= sub ? ~b : b.
  - carry <= cin XOR sub.
  - bit counter <= 0.
  - busy=1 from edge k.
- RUN, each edge: the FA cell adds opA[0], opB[0] and carry.
  - The sum bit shifts into the result shift register at its MSB end.
  - opA and opB shift right; carry <= cell carry; counter increments.
  - On the final step (counter == WIDTH-1), also capture c_msb_in, the carry into the MSB step.
- Completion on edge k+WIDTH:
  - state=DONE, busy=0, done=1 for exactly one cycle.
  - result = full shifted sum, cout = final carry, ovf = c_msb_in XOR final carry.
- Latency: done is visible in the cycle after edge k+WIDTH. Throughput is one op per WIDTH+1 cycles; back-to-back ops are possible by asserting start during DONE.
- start in RUN is ignored. No queuing, and the operand inputs are don't-care after acceptance.
- result, cout and ovf update only at completion. They are not disturbed while a new op runs.
- Width arithmetic: the counter is clog2(WIDTH) bits and must count to WIDTH-1 without wrap error for non-power-of-2 WIDTH (e.g. 5, 12).
- Wrap-around: all-ones + 1 gives result 0 and cout=1, with no side effects.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum (IDLE, RUN, DONE).
  - Function clog2 for the counter width.
- Sub-module fa_cell: purely combinational 1-bit full adder.
  - Inputs a, b, c; outputs s and co.
  - s = a^b^c; co = ab | bc | ac.
  - Instantiated once in serial_addsub.

Test Plan:
- WIDTH=8, add 0xFF+0x01, cin=0, start at edge k -> done only in the cycle after edge k+8; result=0x00, cout=1, ovf=0; busy high for cycles k..k+7.
- Add 0x7F+0x01 -> result=0x80, cout=0, ovf=1. Then add 0x12+0x34 with cin=1 -> 0x47, cout=0, ovf=0.
- Sub 0x05-0x07, cin=0 -> 0xFE, cout=0, ovf=0. Sub 0x80-0x01 -> 0x7F, cout=1, ovf=1. Sub 0x10-0x00 with cin=1 -> 0x0F, cout=1.
- Assert start with different operands on every RUN cycle -> ignored, first op result unchanged. Assert start during the DONE cycle (0x01+0x01) -> busy the next cycle, result 0x02 exactly 9 cycles later, with no idle gap.
- Drop rst_n mid-RUN (cycle 4) -> busy, done and result go to 0 without waiting for a clock edge; after release, a fresh op completes correctly. clear at cycle 3 of RUN -> IDLE next edge, no done pulse, result holds the previous value.
- WIDTH=5 instance, add 0x1F+0x1F, cin=1 -> result=0x1F, cout=1, ovf=0, done after exactly 5 bit-steps.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   // Sequencer states of the serial datapath.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, never less than 1, so a counter of this width reaches value-1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial unit.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: WIDTH-bit operands processed LSB-first through
// one full-adder cell, with a start/busy/done handshake.
module serial_addsub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int               CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last_step;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_co;
   logic             c_msb_in;

   fa_cell u_fa (
      .a  (op_a[0]),
      .b  (op_b[0]),
      .c  (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // On the final step the cell's carry-in is the carry into the MSB.
   assign c_msb_in = carry;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Next-state decode: clear wins over everything, start is honoured only in IDLE/DONE.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_next = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  accept     = 1'b1;
                  state_next = RUN;
               end
            end
            RUN: begin
               if (cnt == LAST) begin
                  last_step  = 1'b1;
                  state_next = DONE;
               end
            end
            DONE: begin
               if (start) begin
                  accept     = 1'b1;
                  state_next = RUN;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Operand latch on accept, then one shift/add step per clock while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_sr <= '0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= cin ^ sub;
         cnt   <= '0;
      end else if (state == RUN && !clear) begin
         op_a   <= op_a >> 1;
         op_b   <= op_b >> 1;
         carry  <= fa_co;
         cnt    <= cnt + CNT_W'(1);
         sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      end
   end

   // Visible results change only when an operation completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (last_step) begin
         result <= {fa_s, sum_sr[WIDTH-1:1]};
         cout   <= fa_co;
         ovf    <= c_msb_in ^ fa_co;
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: scoreboard on the 8-bit instance,
// directed latency/handshake scenarios, plus a 5-bit instance.
module tb_serial_addsub;

   typedef struct packed {
      logic [7:0] r;
      logic       c;
      logic       o;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       clear;
   logic       sub;
   logic       cin;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout;
   logic       ovf;

   logic       start5;
   logic       sub5;
   logic       cin5;
   logic [4:0] a5;
   logic [4:0] b5;
   logic       busy5;
   logic       done5;
   logic [4:0] result5;
   logic       cout5;
   logic       ovf5;

   int   checks;
   int   errors;
   exp_t exp_q[$];

   serial_addsub #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .clear  (clear),
      .sub    (sub),
      .cin    (cin),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   serial_addsub #(.WIDTH(5)) dut5 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start5),
      .clear  (clear),
      .sub    (sub5),
      .cin    (cin5),
      .a      (a5),
      .b      (b5),
      .busy   (busy5),
      .done   (done5),
      .result (result5),
      .cout   (cout5),
      .ovf    (ovf5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic on the 8-bit operands.
   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic ms, input logic mc);
      exp_t e;
      int   u;
      int   sa;
      int   sb;
      int   ss;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (!ms) begin
         u   = int'(ma) + int'(mb) + int'(mc);
         ss  = sa + sb + int'(mc);
         e.c = (u > 255);
      end else begin
         u   = int'(ma) - int'(mb) - int'(mc);
         ss  = sa - sb - int'(mc);
         e.c = (u >= 0);
      end
      e.r = 8'(u);
      e.o = (ss > 127) || (ss < -128);
      return e;
   endfunction

   // Scoreboard: every done pulse of the 8-bit unit is matched against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_done: result=%h cout=%b ovf=%b, no op pending",
                     result, cout, ovf);
         end else begin
            e = exp_q.pop_front();
            if ({result, cout, ovf} !== {e.r, e.c, e.o}) begin
               errors++;
               $display("FAIL scoreboard: result=%h cout=%b ovf=%b, expected result=%h cout=%b ovf=%b",
                        result, cout, ovf, e.r, e.c, e.o);
            end
         end
      end
   end

   // Drive one tracked op and wait (bounded) for done; lat counts edges after the accept edge.
   task automatic op_and_wait(input logic [7:0] ta, input logic [7:0] tb,
                              input logic ts, input logic tc,
                              output int lat, output int nbusy);
      start = 1'b1;
      a     = ta;
      b     = tb;
      sub   = ts;
      cin   = tc;
      exp_q.push_back(model(ta, tb, ts, tc));
      @(posedge clk); #1;
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      lat   = 0;
      nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy, done, result, cout, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h cout=%b ovf=%b, expected all zero",
                  busy, done, result, cout, ovf);
      end
      checks++;
      if ({busy5, done5} !== 2'b00) begin
         errors++;
         $display("FAIL reset_state_w5: busy=%b done=%b, expected 0 0", busy5, done5);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add_wrap();
      int lat;
      int nbusy;
      op_and_wait(8'hFF, 8'h01, 1'b0, 1'b0, lat, nbusy);
      checks++;
      if (lat !== 8) begin
         errors++;
         $display("FAIL wrap_latency: %0d edges, expected 8", lat);
      end
      checks++;
      if (nbusy !== 8) begin
         errors++;
         $display("FAIL wrap_busy_cycles: %0d, expected 8", nbusy);
      end
      checks++;
      if ({result, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL wrap_result: result=%h cout=%b ovf=%b, expected 00 1 0", result, cout, ovf);
      end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL done_single_cycle: done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_add();
      int lat;
      int nbusy;
      op_and_wait(8'h7F, 8'h01, 1'b0, 1'b0, lat, nbusy);
      checks++;
      if ({result, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_overflow: result=%h cout=%b ovf=%b, expected 80 0 1", result, cout, ovf);
      end
      op_and_wait(8'h12, 8'h34, 1'b0, 1'b1, lat, nbusy);
      checks++;
      if ({result, cout, ovf} !== {8'h47, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_cin: result=%h cout=%b ovf=%b, expected 47 0 0", result, cout, ovf);
      end
   endtask

   task automatic test_sub();
      int lat;
      int nbusy;
      op_and_wait(8'h05, 8'h07, 1'b1, 1'b0, lat, nbusy);
      checks++;
      if ({result, cout, ovf} !== {8'hFE, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_negative: result=%h cout=%b ovf=%b, expected FE 0 0", result, cout, ovf);
      end
      op_and_wait(8'h80, 8'h01, 1'b1, 1'b0, lat, nbusy);
      checks++;
      if ({result, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_overflow: result=%h cout=%b ovf=%b, expected 7F 1 1", result, cout, ovf);
      end
      op_and_wait(8'h10, 8'h00, 1'b1, 1'b1, lat, nbusy);
      checks++;
      if ({result, cout} !== {8'h0F, 1'b1}) begin
         errors++;
         $display("FAIL sub_borrow_in: result=%h cout=%b, expected 0F 1", result, cout);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] prev;
      int         held_bad;
      int         cyc;
      prev     = result;
      held_bad = 0;
      start = 1'b1;
      a     = 8'h3C;
      b     = 8'h21;
      sub   = 1'b0;
      cin   = 1'b0;
      exp_q.push_back(model(8'h3C, 8'h21, 1'b0, 1'b0));
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         if (!busy || done || result !== prev) held_bad++;
         start = 1'b1;
         a     = 8'($urandom);
         b     = 8'($urandom);
         sub   = 1'($urandom);
         cin   = 1'($urandom);
         @(posedge clk); #1;
      end
      checks++;
      if (held_bad !== 0) begin
         errors++;
         $display("FAIL run_ignores_start: %0d bad RUN cycles, expected 0", held_bad);
      end
      checks++;
      if ({done, result} !== {1'b1, 8'h5D}) begin
         errors++;
         $display("FAIL first_op_result: done=%b result=%h, expected 1 5D", done, result);
      end
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      sub   = 1'b0;
      cin   = 1'b0;
      exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back_busy: busy=%b, expected 1", busy);
      end
      cyc = 1;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 9 || {done, result} !== {1'b1, 8'h02}) begin
         errors++;
         $display("FAIL back_to_back_latency: %0d cycles result=%h done=%b, expected 9 02 1",
                  cyc, result, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clear();
      logic [7:0] prev;
      int         done_seen;
      prev      = result;
      done_seen = 0;
      clear = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_overrides_start: busy=%b, expected 0", busy);
      end
      clear = 1'b0;
      a     = 8'h55;
      b     = 8'h11;
      sub   = 1'b0;
      cin   = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL clear_to_idle: busy=%b done=%b, expected 0 0", busy, done);
      end
      for (int i = 0; i < 10; i++) begin
         if (done) done_seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (done_seen !== 0 || result !== prev) begin
         errors++;
         $display("FAIL clear_holds_result: done pulses=%0d result=%h, expected 0 %h",
                  done_seen, result, prev);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int nbusy;
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h11;
      sub   = 1'b0;
      cin   = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, cout, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL async_reset_mid_run: busy=%b done=%b result=%h cout=%b ovf=%b, expected all zero",
                  busy, done, result, cout, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op_and_wait(8'h21, 8'h13, 1'b0, 1'b0, lat, nbusy);
      checks++;
      if (lat !== 8 || result !== 8'h34) begin
         errors++;
         $display("FAIL op_after_reset: latency=%0d result=%h, expected 8 34", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat;
      int nbusy;
      int bad_lat;
      bad_lat = 0;
      for (int i = 0; i < 6; i++) begin
         op_and_wait(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, nbusy);
         if (lat !== 8) bad_lat++;
      end
      checks++;
      if (bad_lat !== 0) begin
         errors++;
         $display("FAIL random_latency: %0d ops off 8 edges, expected 0", bad_lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_width5();
      int lat;
      int nbusy;
      start5 = 1'b1;
      a5     = 5'h1F;
      b5     = 5'h1F;
      sub5   = 1'b0;
      cin5   = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      lat    = 0;
      nbusy  = 0;
      while (!done5 && lat < 20) begin
         if (busy5) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 5 || nbusy !== 5) begin
         errors++;
         $display("FAIL w5_latency: %0d edges busy=%0d, expected 5 5", lat, nbusy);
      end
      checks++;
      if ({done5, result5, cout5, ovf5} !== {1'b1, 5'h1F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL w5_result: done=%b result=%h cout=%b ovf=%b, expected 1 1F 1 0",
                  done5, result5, cout5, ovf5);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      clear  = 1'b0;
      sub    = 1'b0;
      cin    = 1'b0;
      a      = '0;
      b      = '0;
      start5 = 1'b0;
      sub5   = 1'b0;
      cin5   = 1'b0;
      a5     = '0;
      b5     = '0;

      test_reset();
      test_add_wrap();
      test_add();
      test_sub();
      test_back_to_back();
      test_clear();
      test_reset_mid_run();
      test_random();
      test_width5();

      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d ops without done, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
